hash_const_seq: RTL and testbench
=================================

# hash_const_seq

Parametrised constant sequencer for the bit-serial hash datapath. It streams SHA-1 or SHA-256 initial-hash words and round constants LSB-first, W bits per beat, under a valid/ready handshake. It supports multi-word bursts with auto-incrementing index and range checking. It replaces ad-hoc per-bit constant selection in the TOTP core with a self-timed source that the round engine pulls from.

## Interface
- `W`, default 1: bits per beat; legal values 1, 2, 4, 8; beats per word = 32/W.
- `SHA256_EN`, default 1: 1 includes the SHA-256 tables; 0 omits them, ignores `mode`, and always uses SHA-1.
- `clk`, input, 1: clock. One clock domain; all logic is on the rising edge.
- `rst_n`, input, 1: reset. Synchronous and active-low.
- `start`, input, 1: request pulse. Sampled only in IDLE.
- `mode`, input, 1: 0 = SHA-1, 1 = SHA-256. Sampled with `start`.
- `kind`, input, 1: 0 = initial-hash word, 1 = round constant. Sampled with `start`.
- `index`, input, 7: first word index. For SHA-1 rounds this is the round number 0..79.
- `len`, input, 4: burst length minus one, so words = `len`+1 (1..16).
- `dout`, output, W: current beat, LSB-first within each word.
- `dvalid`, output, 1: `dout` is valid.
- `dready`, input, 1: consumer accepts the beat.
- `dlast`, output, 1: current beat is the final beat of the final word.
- `busy`, output, 1: sequencer is not in IDLE.
- `err`, output, 1: one-cycle pulse when a request is rejected.

## Operation
- States: IDLE and STREAM.
- **IDLE**
  - `start`=1 triggers a range check on `index` and `index`+`len`.
  - Legal limits: SHA-1 init 0..4; SHA-1 round 0..79; SHA-256 init 0..7; SHA-256 round 0..63.
  - Pass: load word[`index`] into a 32-bit shift register, set beat count = 0, word count = `len`, go to STREAM.
  - Fail: pulse `err` and stay in IDLE.
- **STREAM**
  - `dout` = shift_reg[W-1:0]. `dvalid`=1.
  - On handshake (`dvalid`&`dready`):
    - Shift right by W and increment the beat count.
    - At the final beat of a word with words remaining: increment `index`, load the next word into the shift register, reset the beat count, decrement the word count. There is no bubble between words.
    - At the final beat of the final word: go to IDLE.
  - If `dready`=0, `dout` is held stable.
- SHA-1 round mapping: rounds 0–19 → 5a827999, 20–39 → 6ed9eba1, 40–59 → 8f1bbcdc, 60–79 → ca62c1d6.
- SHA-1 init words: 67452301, efcdab89, 98badcfe, 10325476, c3d2e1f0.
- SHA-256 init words H0..H7 and round constants K0..K63 follow FIPS 180-4.
- When `SHA256_EN`=0, any request is treated as SHA-1 and range-checked accordingly.
- `start` while busy is ignored: no error and no effect.
- Index arithmetic is 7-bit. Wrap-around cannot occur because the start-time check prevents it.

## Timing
- Reset values: `dvalid`=0, `dlast`=0, `busy`=0, `err`=0, `dout`=0, state = IDLE.
- Latency: `start` sampled at edge t gives first beat valid (`dvalid`=1, `busy`=1) after edge t. `err` asserts after edge t for exactly one cycle.
- Throughput: one beat per cycle when `dready` is held high. A burst of N words takes exactly N·32/W cycles.
- `dlast` is combinational from the state and counters, and is high only while the final beat is presented.
- `busy` falls in the cycle after the final handshake, and a new `start` is accepted in that cycle.
- Reset during STREAM returns to IDLE at that edge with `dvalid`=0. The partial burst is discarded.
- Outputs are registered except `dout` (taken from the shift register) and `dlast`. There are no combinational paths from `dready` to `dvalid`.

## Structure
- Package `hash_const_pkg` holds:
  - the mode and kind localparams;
  - the SHA-1 init array [5] and round array [4];
  - the SHA-256 H array [8] and K array [64];
  - index-limit functions.
- Sub-module `hash_const_rom` is a purely combinational lookup (mode, kind, index) → 32-bit word, generated under `SHA256_EN`.
- The top level holds the FSM, shift register, beat/word counters and range check.

## Test plan
- W=1, SHA-1 init, index 0, len 0, `dready`=1 → 32 beats reassemble to 67452301; the first eight beats are 1,0,0,0,0,0,0,0; `dlast` is high on beat 31 only.
- W=4, SHA-256 round, index 0, len 0 → nibbles 8,9,f,2,a,8,2,4 (first word of the stream, 428a2f98); `busy` is low in the cycle after the last handshake.
- W=8, SHA-256 init, index 6, len 1 → bytes ab,d9,83,1f then 19,cd,e0,5b with no gap between words; 8 cycles total.
- W=2, SHA-1 round, index 19, len 1 → words 5a827999 then 6ed9eba1. Toggle `dready` randomly: `dout` holds while stalled and the beat count is exactly 32.
- SHA-1 init, index 4, len 1 → `err` one cycle, no `dvalid`. `start` while busy is ignored. `rst_n`=0 mid-burst → `dvalid`=0 on the next cycle and a fresh `start` works.
- `SHA256_EN`=0 with `mode`=1, round, index 70 → 4 beats of a SHA-1 stream giving ca62c1d6, no `err`.

Source files
------------

// File: rtl/hash_const_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hash_const_pkg
// Description : SHA-1 / SHA-256 constant tables and index-range helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package hash_const_pkg;

   localparam logic c_MODE_SHA1   = 1'b0;
   localparam logic c_MODE_SHA256 = 1'b1;
   localparam logic c_KIND_INIT   = 1'b0;
   localparam logic c_KIND_ROUND  = 1'b1;

   localparam logic [31:0] c_SHA1_INIT [5] = '{
      32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476, 32'hc3d2e1f0
   };

   localparam logic [31:0] c_SHA1_ROUND [4] = '{
      32'h5a827999, 32'h6ed9eba1, 32'h8f1bbcdc, 32'hca62c1d6
   };

   localparam logic [31:0] c_SHA256_H [8] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   localparam logic [31:0] c_SHA256_K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   function automatic logic [7:0] idx_limit(input logic mode, input logic kind);
      if (mode == c_MODE_SHA256) begin
         return (kind == c_KIND_ROUND) ? 8'd63 : 8'd7;
      end
      return (kind == c_KIND_ROUND) ? 8'd79 : 8'd4;
   endfunction

   // Eight-bit sum so index+len can never wrap before the comparison.
   function automatic logic idx_in_range(input logic       mode,
                                         input logic       kind,
                                         input logic [6:0] index,
                                         input logic [3:0] len);
      logic [7:0] last_idx;
      last_idx = {1'b0, index} + {4'b0000, len};
      return ({1'b0, index} <= idx_limit(mode, kind)) &&
             (last_idx      <= idx_limit(mode, kind));
   endfunction

endpackage
`default_nettype wire

// File: rtl/hash_const_rom.sv
`default_nettype none
// ============================================================================
// Module      : hash_const_rom
// Description : Combinational (mode, kind, index) -> 32-bit constant lookup.
// Revision    : 1.0 - initial release
// ============================================================================
module hash_const_rom
   import hash_const_pkg::*;
#(
   parameter bit SHA256_EN = 1'b1
) (
   input  logic        i_mode,
   input  logic        i_kind,
   input  logic [6:0]  i_index,
   output logic [31:0] o_word
);

   logic [31:0] w_sha1_word;

   always_comb begin
      w_sha1_word = 32'h0;
      if (i_kind == c_KIND_ROUND) begin
         if (i_index < 7'd20)      w_sha1_word = c_SHA1_ROUND[0];
         else if (i_index < 7'd40) w_sha1_word = c_SHA1_ROUND[1];
         else if (i_index < 7'd60) w_sha1_word = c_SHA1_ROUND[2];
         else if (i_index < 7'd80) w_sha1_word = c_SHA1_ROUND[3];
      end else if (i_index < 7'd5) begin
         w_sha1_word = c_SHA1_INIT[i_index[2:0]];
      end
   end

   generate
      if (SHA256_EN) begin : g_sha256
         logic [31:0] w_sha256_word;

         always_comb begin
            w_sha256_word = 32'h0;
            if (i_kind == c_KIND_ROUND) begin
               w_sha256_word = c_SHA256_K[i_index[5:0]];
            end else begin
               w_sha256_word = c_SHA256_H[i_index[2:0]];
            end
         end

         assign o_word = (i_mode == c_MODE_SHA256) ? w_sha256_word : w_sha1_word;
      end else begin : g_sha1_only
         logic w_unused_mode;
         assign w_unused_mode = i_mode;
         assign o_word        = w_sha1_word;
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/hash_const_seq.sv
`default_nettype none
// ============================================================================
// Module      : hash_const_seq
// Description : Streams hash constants LSB-first, W bits/beat, valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module hash_const_seq
   import hash_const_pkg::*;
#(
   parameter int W         = 1,
   parameter bit SHA256_EN = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         mode,
   input  logic         kind,
   input  logic [6:0]   index,
   input  logic [3:0]   len,
   output logic [W-1:0] dout,
   output logic         dvalid,
   input  logic         dready,
   output logic         dlast,
   output logic         busy,
   output logic         err
);

   localparam logic [4:0] c_BEAT_LAST = 5'(32 / W - 1);
   localparam logic [0:0] c_IDLE      = 1'b0;
   localparam logic [0:0] c_STREAM    = 1'b1;

   logic [0:0]  r_state;
   logic [31:0] r_shift;
   logic [4:0]  r_beat;
   logic [3:0]  r_words;
   logic [6:0]  r_index;
   logic        r_mode;
   logic        r_kind;
   logic        r_err;

   logic        w_mode;
   logic        w_idle;
   logic        w_range_ok;
   logic        w_word_end;
   logic        w_rom_mode;
   logic        w_rom_kind;
   logic [6:0]  w_rom_index;
   logic [31:0] w_rom_word;

   // Without the SHA-256 tables every request is forced onto the SHA-1 path.
   assign w_mode     = mode & SHA256_EN;
   assign w_idle     = (r_state == c_IDLE);
   assign w_range_ok = idx_in_range(w_mode, kind, index, len);
   assign w_word_end = (r_beat == c_BEAT_LAST);

   // In IDLE the ROM serves the first word; while streaming it prefetches the next.
   assign w_rom_mode  = w_idle ? w_mode : r_mode;
   assign w_rom_kind  = w_idle ? kind   : r_kind;
   assign w_rom_index = w_idle ? index  : (r_index + 7'd1);

   hash_const_rom #(
      .SHA256_EN (SHA256_EN)
   ) u_rom (
      .i_mode  (w_rom_mode),
      .i_kind  (w_rom_kind),
      .i_index (w_rom_index),
      .o_word  (w_rom_word)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= c_IDLE;
         r_shift <= 32'h0;
         r_beat  <= 5'd0;
         r_words <= 4'd0;
         r_index <= 7'd0;
         r_mode  <= c_MODE_SHA1;
         r_kind  <= c_KIND_INIT;
         r_err   <= 1'b0;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            c_IDLE: begin
               if (start) begin
                  if (w_range_ok) begin
                     r_state <= c_STREAM;
                     r_shift <= w_rom_word;
                     r_beat  <= 5'd0;
                     r_words <= len;
                     r_index <= index;
                     r_mode  <= w_mode;
                     r_kind  <= kind;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end
            c_STREAM: begin
               if (dready) begin
                  if (w_word_end && (r_words != 4'd0)) begin
                     r_shift <= w_rom_word;
                     r_beat  <= 5'd0;
                     r_words <= r_words - 4'd1;
                     r_index <= r_index + 7'd1;
                  end else if (w_word_end) begin
                     r_shift <= r_shift >> W;
                     r_beat  <= 5'd0;
                     r_state <= c_IDLE;
                  end else begin
                     r_shift <= r_shift >> W;
                     r_beat  <= r_beat + 5'd1;
                  end
               end
            end
            default: r_state <= c_IDLE;
         endcase
      end
   end

   assign dout   = r_shift[W-1:0];
   assign dvalid = (r_state == c_STREAM);
   assign busy   = (r_state == c_STREAM);
   assign dlast  = (r_state == c_STREAM) && w_word_end && (r_words == 4'd0);
   assign err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_hash_const_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_hash_const_seq
// Description : Directed scoreboard bench over several W / SHA256_EN builds.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hash_const_seq;

   localparam int c_N        = 5;
   localparam int c_WS [c_N] = '{1, 4, 8, 2, 8};
   localparam bit c_EN [c_N] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

   logic              clk = 1'b0;
   logic              rst_n;
   logic [c_N-1:0]    start_a;
   logic              mode;
   logic              kind;
   logic [6:0]        index;
   logic [3:0]        len;
   logic              dready;
   logic [c_N-1:0][7:0] dout_a;
   logic [c_N-1:0]    dvalid_a;
   logic [c_N-1:0]    dlast_a;
   logic [c_N-1:0]    busy_a;
   logic [c_N-1:0]    err_a;

   int          checks   = 0;
   int          failures = 0;
   logic [7:0]  exp_q [$];

   always #5 clk = ~clk;

   generate
      for (genvar g = 0; g < c_N; g++) begin : g_dut
         logic [c_WS[g]-1:0] w_d;
         hash_const_seq #(
            .W         (c_WS[g]),
            .SHA256_EN (c_EN[g])
         ) u_dut (
            .clk    (clk),
            .rst_n  (rst_n),
            .start  (start_a[g]),
            .mode   (mode),
            .kind   (kind),
            .index  (index),
            .len    (len),
            .dout   (w_d),
            .dvalid (dvalid_a[g]),
            .dready (dready),
            .dlast  (dlast_a[g]),
            .busy   (busy_a[g]),
            .err    (err_a[g])
         );
         assign dout_a[g] = 8'(w_d);
      end
   endgenerate

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_word(input int wb, input logic [31:0] word);
      logic [31:0] mask;
      mask = (32'd1 << wb) - 32'd1;
      for (int b = 0; b < 32 / wb; b++) begin
         exp_q.push_back(8'((word >> (b * wb)) & mask));
      end
   endtask

   // Returns at the negedge after the sampling edge of start.
   task automatic start_req(input int g, input logic m, input logic k,
                            input int idx, input int l);
      @(negedge clk);
      mode = m; kind = k; index = 7'(idx); len = 4'(l);
      start_a[g] = 1'b1;
      @(negedge clk);
      start_a[g] = 1'b0;
   endtask

   task automatic drain(input int g, input int wb, input bit rnd,
                        output int cyc, output int beats);
      logic [7:0] mask;
      logic [7:0] exp;
      logic [7:0] prev_dout;
      bit         prev_stall;
      mask       = 8'((1 << wb) - 1);
      cyc        = 0;
      beats      = 0;
      prev_stall = 1'b0;
      prev_dout  = 8'h0;
      while (exp_q.size() > 0 && cyc < 4000) begin
         dready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         check("dvalid_in_burst", 32'(dvalid_a[g]), 32'd1);
         if (prev_stall) check("dout_hold", 32'(dout_a[g] & mask), 32'(prev_dout));
         if (dvalid_a[g]) begin
            check("dlast", 32'(dlast_a[g]), 32'(exp_q.size() == 1));
            if (dready) begin
               exp = exp_q.pop_front();
               check("dout_beat", 32'(dout_a[g] & mask), 32'(exp));
               beats++;
            end
         end
         prev_stall = dvalid_a[g] && !dready;
         prev_dout  = dout_a[g] & mask;
         @(negedge clk);
         cyc++;
      end
      if (exp_q.size() > 0) begin
         check("drain_timeout", 32'(exp_q.size()), 32'd0);
         exp_q.delete();
      end
      dready = 1'b0;
   endtask

   initial begin
      int cyc;
      int beats;
      rst_n = 1'b0; start_a = '0; mode = 1'b0; kind = 1'b0;
      index = 7'd0; len = 4'd0; dready = 1'b0;
      repeat (3) @(negedge clk);
      for (int g = 0; g < c_N; g++) begin
         check("rst_dvalid", 32'(dvalid_a[g]), 32'd0);
         check("rst_busy",   32'(busy_a[g]),   32'd0);
         check("rst_err",    32'(err_a[g]),    32'd0);
         check("rst_dlast",  32'(dlast_a[g]),  32'd0);
         check("rst_dout",   32'(dout_a[g]),   32'd0);
      end
      rst_n = 1'b1;

      // W=1 SHA-1 H0
      push_word(1, 32'h67452301);
      start_req(0, 1'b0, 1'b0, 0, 0);
      drain(0, 1, 1'b0, cyc, beats);
      check("w1_cycles", 32'(cyc), 32'd32);
      check("w1_busy_after", 32'(busy_a[0]), 32'd0);

      // W=4 SHA-256 K0, with a start while busy that must be ignored
      push_word(4, 32'h428a2f98);
      start_req(1, 1'b1, 1'b1, 0, 0);
      index = 7'd5; len = 4'd3; start_a[1] = 1'b1; dready = 1'b0;
      @(negedge clk);
      start_a[1] = 1'b0;
      check("busy_start_err", 32'(err_a[1]), 32'd0);
      drain(1, 4, 1'b0, cyc, beats);
      check("w4_cycles", 32'(cyc), 32'd8);
      check("w4_busy_after", 32'(busy_a[1]), 32'd0);

      // Reset mid-burst
      start_req(2, 1'b1, 1'b0, 0, 3);
      dready = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("rst_mid_dvalid", 32'(dvalid_a[2]), 32'd0);
      check("rst_mid_busy",   32'(busy_a[2]),   32'd0);
      rst_n = 1'b1; dready = 1'b0;

      // W=8 SHA-256 H6,H7 back to back
      push_word(8, 32'h1f83d9ab);
      push_word(8, 32'h5be0cd19);
      start_req(2, 1'b1, 1'b0, 6, 1);
      drain(2, 8, 1'b0, cyc, beats);
      check("w8_cycles", 32'(cyc), 32'd8);

      // W=2 SHA-1 rounds 19,20 with random backpressure
      push_word(2, 32'h5a827999);
      push_word(2, 32'h6ed9eba1);
      start_req(3, 1'b0, 1'b1, 19, 1);
      drain(3, 2, 1'b1, cyc, beats);
      check("w2_beats", 32'(beats), 32'd32);
      check("w2_busy_after", 32'(busy_a[3]), 32'd0);

      // Out-of-range SHA-1 init request
      start_req(0, 1'b0, 1'b0, 4, 1);
      check("err_pulse",  32'(err_a[0]),    32'd1);
      check("err_dvalid", 32'(dvalid_a[0]), 32'd0);
      @(negedge clk);
      check("err_clear",   32'(err_a[0]),    32'd0);
      check("err_dvalid2", 32'(dvalid_a[0]), 32'd0);

      // Out-of-range SHA-256 round burst (60+4 > 63)
      start_req(1, 1'b1, 1'b1, 60, 4);
      check("err256_pulse",  32'(err_a[1]),    32'd1);
      check("err256_dvalid", 32'(dvalid_a[1]), 32'd0);

      // SHA256_EN=0: mode ignored, round 70 is SHA-1
      push_word(8, 32'hca62c1d6);
      start_req(4, 1'b1, 1'b1, 70, 0);
      check("sha1only_err", 32'(err_a[4]), 32'd0);
      drain(4, 8, 1'b0, cyc, beats);
      check("sha1only_cycles", 32'(cyc), 32'd4);

      // Upper SHA-1 round boundary is legal
      push_word(8, 32'hca62c1d6);
      start_req(4, 1'b0, 1'b1, 79, 0);
      check("r79_err", 32'(err_a[4]), 32'd0);
      drain(4, 8, 1'b0, cyc, beats);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
